// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - state encoding, unit constants and letter pattern table for the Morse sequencer
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_LGAP  = 2'd3
    } state_t;

    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int NUM_LETTERS      = 26;

    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [3:0] pattern;
    } rom_entry_t;

    // pattern bit i is element i, 1 = dash; first element sent is bit 0
    function automatic rom_entry_t letter_entry(input logic [4:0] idx);
        rom_entry_t e;
        e = '0;
        case (idx)
            5'd0:  e = {1'b1, 3'd2, 4'b0010};
            5'd1:  e = {1'b1, 3'd4, 4'b0001};
            5'd2:  e = {1'b1, 3'd4, 4'b0101};
            5'd3:  e = {1'b1, 3'd3, 4'b0001};
            5'd4:  e = {1'b1, 3'd1, 4'b0000};
            5'd5:  e = {1'b1, 3'd4, 4'b0100};
            5'd6:  e = {1'b1, 3'd3, 4'b0011};
            5'd7:  e = {1'b1, 3'd4, 4'b0000};
            5'd8:  e = {1'b1, 3'd2, 4'b0000};
            5'd9:  e = {1'b1, 3'd4, 4'b1110};
            5'd10: e = {1'b1, 3'd3, 4'b0101};
            5'd11: e = {1'b1, 3'd4, 4'b0010};
            5'd12: e = {1'b1, 3'd2, 4'b0011};
            5'd13: e = {1'b1, 3'd2, 4'b0001};
            5'd14: e = {1'b1, 3'd3, 4'b0111};
            5'd15: e = {1'b1, 3'd4, 4'b0110};
            5'd16: e = {1'b1, 3'd4, 4'b1011};
            5'd17: e = {1'b1, 3'd3, 4'b0010};
            5'd18: e = {1'b1, 3'd3, 4'b0000};
            5'd19: e = {1'b1, 3'd1, 4'b0001};
            5'd20: e = {1'b1, 3'd3, 4'b0100};
            5'd21: e = {1'b1, 3'd4, 4'b1000};
            5'd22: e = {1'b1, 3'd3, 4'b0110};
            5'd23: e = {1'b1, 3'd4, 4'b1001};
            5'd24: e = {1'b1, 3'd4, 4'b1101};
            5'd25: e = {1'b1, 3'd4, 4'b0011};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational letter index to Morse length/pattern lookup
import morse_pkg::*;

module morse_rom (
    input  logic [4:0] letter_idx,
    output logic       valid,
    output logic [2:0] len,
    output logic [3:0] pattern
);

    rom_entry_t entry;

    assign entry   = letter_entry(letter_idx);
    assign valid   = entry.valid;
    assign len     = entry.len;
    assign pattern = entry.pattern;

endmodule

// File: rtl/morse_letter_sequencer.sv
// rtl/morse_letter_sequencer.sv - plays one Morse letter: mark/gap timing FSM and display status outputs
import morse_pkg::*;

module morse_letter_sequencer #(
    parameter int UNIT_CYCLES = 1000000,
    parameter int CYC_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] letter_idx,
    input  logic       letter_valid,
    output logic       letter_ready,
    input  logic       stop,
    output logic       tone,
    output logic       busy,
    output logic [2:0] cur_len,
    output logic [3:0] cur_pattern,
    output logic [1:0] elem_idx,
    output logic       letter_done,
    output logic       err
);

    state_t           state, state_n;
    logic [CYC_W-1:0] cyc_cnt, cyc_n;
    logic [1:0]       unit_cnt, unit_n;
    logic [1:0]       elem_n;
    logic [2:0]       len_n;
    logic [3:0]       pat_n;
    logic             done_n, err_n;

    logic             rom_valid;
    logic [2:0]       rom_len;
    logic [3:0]       rom_pattern;
    logic [1:0]       phase_units;
    logic             unit_end, phase_end, last_elem;

    morse_rom u_rom (
        .letter_idx (letter_idx),
        .valid      (rom_valid),
        .len        (rom_len),
        .pattern    (rom_pattern)
    );

    always_comb begin
        phase_units = 2'(LETTER_GAP_UNITS);
        case (state)
            ST_MARK:  phase_units = cur_pattern[elem_idx] ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
            ST_SPACE: phase_units = 2'(ELEM_GAP_UNITS);
            default:  phase_units = 2'(LETTER_GAP_UNITS);
        endcase
    end

    assign unit_end  = (cyc_cnt == CYC_W'(UNIT_CYCLES - 1));
    assign phase_end = unit_end && (unit_cnt == phase_units - 2'd1);
    assign last_elem = (({1'b0, elem_idx} + 3'd1) >= cur_len);

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        unit_n  = unit_cnt;
        elem_n  = elem_idx;
        len_n   = cur_len;
        pat_n   = cur_pattern;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (state == ST_IDLE) begin
            cyc_n  = '0;
            unit_n = '0;
            // stop outranks a request while idle, so nothing is taken that cycle
            if (letter_valid && !stop) begin
                if (rom_valid) begin
                    state_n = ST_MARK;
                    len_n   = rom_len;
                    pat_n   = rom_pattern;
                    elem_n  = '0;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (stop) begin
            state_n = ST_IDLE;
            cyc_n   = '0;
            unit_n  = '0;
        end else if (phase_end) begin
            cyc_n  = '0;
            unit_n = '0;
            case (state)
                ST_MARK:  state_n = last_elem ? ST_LGAP : ST_SPACE;
                ST_SPACE: begin
                    state_n = ST_MARK;
                    elem_n  = elem_idx + 2'd1;
                end
                ST_LGAP: begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
                default:  state_n = ST_IDLE;
            endcase
        end else if (unit_end) begin
            cyc_n  = '0;
            unit_n = unit_cnt + 2'd1;
        end else begin
            cyc_n = cyc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cyc_cnt     <= '0;
            unit_cnt    <= '0;
            elem_idx    <= '0;
            cur_len     <= '0;
            cur_pattern <= '0;
            letter_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            cyc_cnt     <= cyc_n;
            unit_cnt    <= unit_n;
            elem_idx    <= elem_n;
            cur_len     <= len_n;
            cur_pattern <= pat_n;
            letter_done <= done_n;
            err         <= err_n;
        end
    end

    assign tone         = (state == ST_MARK);
    assign busy         = (state != ST_IDLE);
    assign letter_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// tb/tb_morse_letter_sequencer.sv - directed table-driven bench for the Morse letter sequencer
module tb_morse_letter_sequencer;

    localparam int UC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] letter_idx;
    logic       letter_valid;
    logic       letter_ready;
    logic       stop;
    logic       tone;
    logic       busy;
    logic [2:0] cur_len;
    logic [3:0] cur_pattern;
    logic [1:0] elem_idx;
    logic       letter_done;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] idx;
        logic [2:0] len;
        logic [3:0] pat;
    } vec_t;

    vec_t tbl[26];

    always #5 clk = ~clk;

    morse_letter_sequencer #(.UNIT_CYCLES(UC), .CYC_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .letter_idx   (letter_idx),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .stop         (stop),
        .tone         (tone),
        .busy         (busy),
        .cur_len      (cur_len),
        .cur_pattern  (cur_pattern),
        .elem_idx     (elem_idx),
        .letter_done  (letter_done),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_in(input bit en);
        if (en) begin
            letter_valid = 1'($urandom_range(0, 1));
            letter_idx   = 5'($urandom_range(0, 31));
        end
    endtask

    // prereq: request was already presented in the current cycle by the caller
    task automatic play(input logic [4:0] idx, input logic [2:0] len, input logic [3:0] pat,
                        input bit prereq, input bit chain, input logic [4:0] chain_idx, input bit noise);
        if (!prereq) begin
            letter_idx   = idx;
            letter_valid = 1'b1;
        end
        step();
        letter_valid = 1'b0;
        for (int e = 0; e < int'(len); e++) begin
            for (int c = 0; c < (pat[e] ? 3 : 1) * UC; c++) begin
                check("mark_tone", tone, 1'b1);
                check("mark_elem", elem_idx, e);
                check("mark_busy", busy, 1'b1);
                noise_in(noise);
                step();
            end
            if (e < int'(len) - 1) begin
                for (int c = 0; c < UC; c++) begin
                    check("space_tone", tone, 1'b0);
                    check("space_elem", elem_idx, e);
                    check("space_busy", busy, 1'b1);
                    noise_in(noise);
                    step();
                end
            end
        end
        for (int c = 0; c < 3 * UC; c++) begin
            check("lgap_tone", tone, 1'b0);
            check("lgap_busy", busy, 1'b1);
            check("lgap_done", letter_done, 1'b0);
            noise_in(noise);
            step();
        end
        check("done_pulse", letter_done, 1'b1);
        check("done_ready", letter_ready, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_len", cur_len, len);
        check("done_pat", cur_pattern, pat);
        letter_valid = chain;
        letter_idx   = chain_idx;
        if (!chain) begin
            step();
            check("done_clear", letter_done, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        int pulses;
        tbl[0]  = '{5'd0,  3'd2, 4'b0010};  tbl[1]  = '{5'd1,  3'd4, 4'b0001};
        tbl[2]  = '{5'd2,  3'd4, 4'b0101};  tbl[3]  = '{5'd3,  3'd3, 4'b0001};
        tbl[4]  = '{5'd4,  3'd1, 4'b0000};  tbl[5]  = '{5'd5,  3'd4, 4'b0100};
        tbl[6]  = '{5'd6,  3'd3, 4'b0011};  tbl[7]  = '{5'd7,  3'd4, 4'b0000};
        tbl[8]  = '{5'd8,  3'd2, 4'b0000};  tbl[9]  = '{5'd9,  3'd4, 4'b1110};
        tbl[10] = '{5'd10, 3'd3, 4'b0101};  tbl[11] = '{5'd11, 3'd4, 4'b0010};
        tbl[12] = '{5'd12, 3'd2, 4'b0011};  tbl[13] = '{5'd13, 3'd2, 4'b0001};
        tbl[14] = '{5'd14, 3'd3, 4'b0111};  tbl[15] = '{5'd15, 3'd4, 4'b0110};
        tbl[16] = '{5'd16, 3'd4, 4'b1011};  tbl[17] = '{5'd17, 3'd3, 4'b0010};
        tbl[18] = '{5'd18, 3'd3, 4'b0000};  tbl[19] = '{5'd19, 3'd1, 4'b0001};
        tbl[20] = '{5'd20, 3'd3, 4'b0100};  tbl[21] = '{5'd21, 3'd4, 4'b1000};
        tbl[22] = '{5'd22, 3'd3, 4'b0110};  tbl[23] = '{5'd23, 3'd4, 4'b1001};
        tbl[24] = '{5'd24, 3'd4, 4'b1101};  tbl[25] = '{5'd25, 3'd4, 4'b0011};

        reset = 1'b1; letter_valid = 1'b0; letter_idx = '0; stop = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        check("rst_tone", tone, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", letter_ready, 1'b1);
        check("rst_done", letter_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_elem", elem_idx, 2'd0);
        check("rst_len", cur_len, 3'd0);
        check("rst_pat", cur_pattern, 4'd0);

        play(5'd0, 3'd2, 4'b0010, 1'b0, 1'b0, 5'd0, 1'b0);

        play(5'd4, 3'd1, 4'b0000, 1'b0, 1'b1, 5'd19, 1'b0);
        play(5'd19, 3'd1, 4'b0001, 1'b1, 1'b0, 5'd0, 1'b0);

        for (int i = 26; i < 32; i++) begin
            letter_idx = 5'(i); letter_valid = 1'b1;
            step();
            letter_valid = 1'b0;
            check("inv_err", err, 1'b1);
            check("inv_busy", busy, 1'b0);
            check("inv_tone", tone, 1'b0);
            check("inv_len", cur_len, 3'd1);
            check("inv_pat", cur_pattern, 4'b0001);
            step();
            check("inv_err_clear", err, 1'b0);
            check("inv_busy2", busy, 1'b0);
        end

        letter_idx = 5'd16; letter_valid = 1'b1;
        step();
        letter_valid = 1'b0;
        repeat (19) step();
        check("q_dash2_tone", tone, 1'b1);
        check("q_dash2_elem", elem_idx, 2'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tone", tone, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_ready", letter_ready, 1'b1);
        check("stop_len", cur_len, 3'd4);
        check("stop_pat", cur_pattern, 4'b1011);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (letter_done === 1'b1 || busy !== 1'b0) pulses++;
            step();
        end
        check("stop_no_done", pulses, 0);
        stop = 1'b1; letter_valid = 1'b1; letter_idx = 5'd0;
        step();
        stop = 1'b0; letter_valid = 1'b0;
        check("stop_idle_busy", busy, 1'b0);
        check("stop_idle_len", cur_len, 3'd4);
        play(5'd18, 3'd3, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b0);

        letter_idx = 5'd1; letter_valid = 1'b1;
        step();
        letter_valid = 1'b0;
        repeat (13) step();
        check("b_space_tone", tone, 1'b0);
        check("b_space_busy", busy, 1'b1);
        reset = 1'b1; letter_valid = 1'b1; letter_idx = 5'd0;
        step();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tone", tone, 1'b0);
        check("mid_rst_len", cur_len, 3'd0);
        check("mid_rst_pat", cur_pattern, 4'd0);
        check("mid_rst_elem", elem_idx, 2'd0);
        check("mid_rst_ready", letter_ready, 1'b1);
        step();
        reset = 1'b0; letter_valid = 1'b0;
        step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_len", cur_len, 3'd0);

        for (int i = 0; i < 26; i++) begin
            play(tbl[i].idx, tbl[i].len, tbl[i].pat, 1'b0, 1'b0, 5'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
